// File: rtl/pattern_pkg.sv
// Shared types and constants for the test-pattern frame sequencer.
package pattern_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    HBLK = 2'd2,
    VBLK = 2'd3
  } state_t;

  localparam logic [1:0] MODE_X   = 2'd0;
  localparam logic [1:0] MODE_Y   = 2'd1;
  localparam logic [1:0] MODE_RUN = 2'd2;
  localparam logic [1:0] MODE_CHK = 2'd3;

  localparam logic [PIX_W-1:0] CHK_A = 8'hA5;
  localparam logic [PIX_W-1:0] CHK_B = 8'h5A;

endpackage

// File: rtl/pattern_frame_ctrl_if.sv
// Parallel pixel bus toward the capture sink: pixel clock, frame/line valid and data.
interface pattern_frame_ctrl_if;
  import pattern_pkg::*;

  logic             pclk;
  logic             fval;
  logic             lval;
  logic [PIX_W-1:0] data_out;

  modport master (output pclk, output fval, output lval, output data_out);
  modport slave  (input  pclk, input  fval, input  lval, input  data_out);
endinterface

// File: rtl/pattern_frame_ctrl_pclk_divider.sv
// Pixel-rate divider: div counter, registered pclk and a tick on the last cycle of each pixel.
module pclk_divider #(
  parameter int PCLK_DIV = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        en,
  output logic [$clog2(PCLK_DIV)-1:0] div,
  output logic                        pclk,
  output logic                        tick
);
  localparam int DW = $clog2(PCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(PCLK_DIV / 2);

  logic [DW-1:0] div_n;

  assign tick = en && (div == DIV_LAST);

  always_comb begin
    div_n = '0;
    if (en && !tick) div_n = div + 1'b1;
  end

  // pclk is derived from the next count so it is glitch-free and low while disabled
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div  <= '0;
      pclk <= 1'b0;
    end else begin
      div  <= div_n;
      pclk <= (div_n >= DIV_HALF);
    end
  end
endmodule

// File: rtl/pattern_frame_ctrl.sv
// Frame/line sequencer emulating image-sensor timing on the parallel pixel bus.
module pattern_frame_ctrl
  import pattern_pkg::*;
#(
  parameter int          H_ACTIVE  = 16,
  parameter int          H_BLANK   = 4,
  parameter int          V_ACTIVE  = 8,
  parameter int          V_BLANK   = 2,
  parameter int          PCLK_DIV  = 2,
  parameter logic [15:0] CNT_RESET = 16'h0000
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  mode,
  pattern_frame_ctrl_if.master        pix,
  output logic                        busy,
  output logic                        frame_done,
  output logic [15:0]                 frame_cnt
);
  localparam int H_TOT = H_ACTIVE + H_BLANK;
  localparam int V_TOT = V_ACTIVE + V_BLANK;
  localparam int XW    = $clog2(H_TOT);
  localparam int YW    = (V_TOT > 2) ? $clog2(V_TOT) : 1;
  localparam int DW    = $clog2(PCLK_DIV);

  localparam logic [XW-1:0] X_LAST_ACT = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(H_TOT - 1);
  localparam logic [YW-1:0] Y_LAST_ACT = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_TOT - 1);
  localparam logic [DW-1:0] DIV_PEN    = DW'(PCLK_DIV - 2);

  state_t           state;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] run;
  logic             stop_q;
  logic             busy_q, fval_q, lval_q, done_q;
  logic [PIX_W-1:0] data_q;
  logic [15:0]      cnt_q;
  logic [DW-1:0]    div;
  logic             pclk_w, tick;
  logic             done_set;

  function automatic logic [PIX_W-1:0] pix_value(input logic [1:0] m, input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py, input logic [PIX_W-1:0] rb);
    case (m)
      MODE_X:   return PIX_W'(px);
      MODE_Y:   return PIX_W'(py);
      MODE_RUN: return rb;
      default:  return px[0] ? CHK_B : CHK_A;
    endcase
  endfunction

  pclk_divider #(.PCLK_DIV(PCLK_DIV)) u_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (busy_q),
    .div       (div),
    .pclk      (pclk_w),
    .tick      (tick)
  );

  // Raised one cycle early so the registered pulse covers the final VBLK cycle
  assign done_set = (state == VBLK) && (x == X_LAST) && (y == Y_LAST) && (div == DIV_PEN);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      mode_q <= MODE_X;
      run    <= '0;
      stop_q <= 1'b0;
      busy_q <= 1'b0;
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= CNT_RESET;
    end else begin
      done_q <= done_set;
      if (done_set) cnt_q <= cnt_q + 16'd1;
      if (state != IDLE && stop) stop_q <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LINE;
            busy_q <= 1'b1;
            fval_q <= 1'b1;
            lval_q <= 1'b1;
            x      <= '0;
            y      <= '0;
            mode_q <= mode;
            data_q <= pix_value(mode, '0, '0, '0);
            run    <= 8'd1;
            stop_q <= stop;
          end
        end
        LINE: if (tick) begin
          x <= x + 1'b1;
          if (x == X_LAST_ACT) begin
            state  <= HBLK;
            lval_q <= 1'b0;
            data_q <= '0;
          end else begin
            data_q <= pix_value(mode_q, x + 1'b1, y, run);
            run    <= run + 8'd1;
          end
        end
        HBLK: if (tick) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= y + 1'b1;
            if (y == Y_LAST_ACT) begin
              state  <= VBLK;
              fval_q <= 1'b0;
            end else begin
              state  <= LINE;
              lval_q <= 1'b1;
              data_q <= pix_value(mode_q, '0, y + 1'b1, run);
              run    <= run + 8'd1;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
        VBLK: if (tick) begin
          if (x == X_LAST) begin
            x <= '0;
            if (y == Y_LAST) begin
              y <= '0;
              // A stop arriving on the very last cycle still ends the stream here
              if (stop_q || stop) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                stop_q <= 1'b0;
              end else begin
                state  <= LINE;
                fval_q <= 1'b1;
                lval_q <= 1'b1;
                mode_q <= mode;
                data_q <= pix_value(mode, '0, '0, '0);
                run    <= 8'd1;
              end
            end else begin
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pix.pclk     = pclk_w;
  assign pix.fval     = fval_q;
  assign pix.lval     = lval_q;
  assign pix.data_out = data_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign frame_cnt    = cnt_q;
endmodule

// File: tb/tb_pattern_frame_ctrl.sv
// Randomized bench for pattern_frame_ctrl against a cycle-index frame model.
module tb_pattern_frame_ctrl;
  import pattern_pkg::*;

  localparam int H_A  = 4;
  localparam int H_B  = 2;
  localparam int V_A  = 3;
  localparam int V_B  = 1;
  localparam int DIV  = 2;
  localparam int H_T  = H_A + H_B;
  localparam int V_T  = V_A + V_B;
  localparam int FLEN = H_T * V_T * DIV;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        busy, frame_done;
  logic [15:0] frame_cnt;

  logic        start2 = 1'b0, stop2 = 1'b0;
  logic        busy2, done2;
  logic [15:0] cnt2;

  pattern_frame_ctrl_if pix ();
  pattern_frame_ctrl_if pix2 ();

  pattern_frame_ctrl #(.H_ACTIVE(H_A), .H_BLANK(H_B), .V_ACTIVE(V_A), .V_BLANK(V_B),
                       .PCLK_DIV(DIV)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop), .mode(mode),
    .pix(pix), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt));

  pattern_frame_ctrl #(.H_ACTIVE(H_A), .H_BLANK(H_B), .V_ACTIVE(V_A), .V_BLANK(V_B),
                       .PCLK_DIV(DIV), .CNT_RESET(16'hFFFE)) dut_wrap (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start2), .stop(stop2), .mode(2'd0),
    .pix(pix2), .busy(busy2), .frame_done(done2), .frame_cnt(cnt2));

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a busy stream is just a cycle index into the current frame
  bit m_busy, m_stop;
  int m_k, m_mode, m_cnt;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_busy = 0; m_stop = 0; m_k = 0; m_mode = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_k = 0; m_mode = int'(mode); m_stop = stop;
      end
    end else begin
      if (stop) m_stop = 1;
      m_k++;
      if (m_k == FLEN - 1) m_cnt = (m_cnt + 1) % 65536;
      if (m_k == FLEN) begin
        m_k = 0;
        if (m_stop) begin
          m_busy = 0; m_stop = 0;
        end else begin
          m_mode = int'(mode);
        end
      end
    end
  end

  function automatic logic [7:0] exp_data(input int m, input int px, input int py);
    int v;
    case (m)
      0:       v = px;
      1:       v = py;
      2:       v = py * H_A + px;
      default: v = (px % 2 != 0) ? 'h5A : 'hA5;
    endcase
    return v[7:0];
  endfunction

  task automatic compare_all();
    int p, px, py;
    logic ep, ef, el, edn;
    logic [7:0] ed;
    ep = 0; ef = 0; el = 0; ed = 8'h00; edn = 0;
    if (m_busy) begin
      p  = m_k / DIV;
      px = p % H_T;
      py = p / H_T;
      ep = (m_k % DIV) >= DIV / 2;
      ef = py < V_A;
      el = ef && (px < H_A);
      ed = el ? exp_data(m_mode, px, py) : 8'h00;
      edn = (m_k == FLEN - 1);
    end
    check_eq("pclk", pix.pclk, ep);
    check_eq("fval", pix.fval, ef);
    check_eq("lval", pix.lval, el);
    check_eq("data_out", pix.data_out, ed);
    check_eq("busy", busy, m_busy);
    check_eq("frame_done", frame_done, edn);
    check_eq("frame_cnt", frame_cnt, m_cnt[15:0]);
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (chk_on) compare_all();
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse(input bit s, input bit p, input logic [1:0] m);
    @(negedge sys_clk);
    start = s; stop = p; mode = m;
    @(negedge sys_clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic wait_idle2(input int maxc, input string tag);
    int n;
    n = 0;
    while (busy2 && n < maxc) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq(tag, busy2, 1'b0);
  endtask

  initial begin
    chk_on = 1'b1;
    idle(3);
    sys_rst_n = 1'b1;
    idle(2);

    // single frame, start and stop together
    pulse(1, 1, 2'd0);
    idle(60);
    check_eq("single_cnt", frame_cnt, 16'd1);

    // continuous mode 1, stop during frame 2
    pulse(1, 0, 2'd1);
    idle(FLEN + 15);
    pulse(0, 1, 2'd1);
    wait_idle(3 * FLEN, "mode1_drain");
    check_eq("mode1_cnt", frame_cnt, 16'd3);

    // mode 2 with a mid-frame mode change
    pulse(1, 0, 2'd2);
    idle(20);
    mode = 2'($urandom_range(0, 3));
    idle(40);
    pulse(0, 1, mode);
    wait_idle(3 * FLEN, "mode2_drain");

    // mode 3 checkerboard
    pulse(1, 1, 2'd3);
    wait_idle(2 * FLEN, "mode3_drain");

    // asynchronous reset in the middle of a line
    pulse(1, 0, 2'($urandom_range(0, 3)));
    idle(8);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    check_eq("rst_pclk", pix.pclk, 1'b0);
    check_eq("rst_fval", pix.fval, 1'b0);
    check_eq("rst_lval", pix.lval, 1'b0);
    check_eq("rst_data", pix.data_out, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cnt", frame_cnt, 16'h0000);
    compare_all();
    idle(2);
    sys_rst_n = 1'b1;
    idle(2);
    pulse(1, 1, 2'd0);
    idle(20);
    check_eq("rst_fresh_cnt", frame_cnt, 16'd0);
    wait_idle(2 * FLEN, "rst_fresh_drain");
    check_eq("rst_fresh_done_cnt", frame_cnt, 16'd1);

    // stop in IDLE ignored, start while busy ignored
    pulse(0, 1, 2'd0);
    idle(3);
    pulse(1, 0, 2'd3);
    for (int c = 0; c < 3 * FLEN; c++) begin
      @(negedge sys_clk);
      start = ($urandom_range(0, 7) == 0);
      mode  = 2'($urandom_range(0, 3));
    end
    start = 1'b0;
    check_eq("cont_busy", busy, 1'b1);
    pulse(0, 1, 2'd0);
    wait_idle(2 * FLEN, "cont_drain");

    // randomized streams
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < 150; c++) begin
        @(negedge sys_clk);
        start = ($urandom_range(0, 15) == 0);
        stop  = ($urandom_range(0, 63) == 0);
        mode  = 2'($urandom_range(0, 3));
      end
      start = 1'b0;
      pulse(0, 1, mode);
      wait_idle(2 * FLEN + 4, "rand_drain");
    end

    // frame counter wrap on the preloaded instance
    @(negedge sys_clk); start2 = 1'b1; stop2 = 1'b1;
    @(negedge sys_clk); start2 = 1'b0; stop2 = 1'b0;
    wait_idle2(2 * FLEN, "wrap_drain1");
    check_eq("wrap_ffff", cnt2, 16'hFFFF);
    @(negedge sys_clk); start2 = 1'b1; stop2 = 1'b1;
    @(negedge sys_clk); start2 = 1'b0; stop2 = 1'b0;
    wait_idle2(2 * FLEN, "wrap_drain2");
    check_eq("wrap_zero", cnt2, 16'h0000);

    idle(2);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
